axi4l_mif: RTL and testbench
============================

Name: axi4l_mif

Overview:
- AXI4-Lite master (initiator) interface. It turns single-beat local write and read requests into AXI4-Lite transactions and returns the responses to the local requester.
- It is the initiator-side counterpart of the team's AXI4-Lite slave shim. It sits between in-fabric controllers (DMA descriptors, sequencers) and an AXI4-Lite interconnect.
- Write and read paths are independent and run concurrently.

Parameters:
- axi4l__addr_width, 64, AXI/local address width.
- axi4l__data_width, 32, AXI/local data width; must be 32 or 64.
- axi4l__prot, 3'b000, constant value driven on awprot/arprot.

Ports:
- Clock and reset: reset is synchronous and active-low.
  - sys__clk in 1: the single clock.
  - sys__srstn in 1: synchronous, active-low reset.
- Local write request:
  - req__waddr in AW: write address.
  - req__wdata in DW: write data.
  - req__wstrb in DW/8: write byte strobes.
  - req__wvalid in 1: write request valid.
  - req__wready out 1: write request accepted.
- Local write response:
  - req__bresp out 2: write response code.
  - req__bvalid out 1: write response valid.
  - req__bready in 1: requester accepts write response.
- Local read request:
  - req__raddr in AW: read address.
  - req__arvalid in 1: read request valid.
  - req__arready out 1: read request accepted.
- Local read response:
  - req__rdata out DW: read data.
  - req__rresp out 2: read response code.
  - req__rvalid out 1: read response valid.
  - req__rready in 1: requester accepts read response.
- AXI write channels: axi4l__m_awaddr out AW, axi4l__m_awprot out 3, axi4l__m_awvalid out 1, axi4l__m_awready in 1, axi4l__m_wdata out DW, axi4l__m_wstrb out DW/8, axi4l__m_wvalid out 1, axi4l__m_wready in 1, axi4l__m_bresp in 2, axi4l__m_bvalid in 1, axi4l__m_bready out 1.
- AXI read channels: axi4l__m_araddr out AW, axi4l__m_arprot out 3, axi4l__m_arvalid out 1, axi4l__m_arready in 1, axi4l__m_rdata in DW, axi4l__m_rresp in 2, axi4l__m_rvalid in 1, axi4l__m_rready out 1.

Behaviour:
- Reset: sys__srstn low at a clock edge forces both FSMs to IDLE and clears all capture registers and aw_done/w_done flags to 0.
  - After that edge: every AXI valid/ready output = 0, req__bvalid = req__rvalid = 0, req__wready = req__arready = 1, all data/addr/resp outputs = 0.
  - Reset mid-transaction abandons the transaction immediately. Valids drop the cycle after the reset edge. The interconnect/slave must be reset together.
- Write FSM, one-hot states IDLE, ADDR, RESP, DONE:
  - IDLE: req__wready = 1. If req__wvalid, capture waddr/wdata/wstrb, clear aw_done/w_done, go to ADDR.
  - ADDR: awvalid = !aw_done and wvalid = !w_done, each independent. AW and W may complete in either order or in the same cycle. Set aw_done on awvalid&&awready; set w_done on wvalid&&wready. Go to RESP in the cycle after both handshakes complete. This includes both completing in the same cycle.
  - RESP: bready = 1. On bvalid, capture bresp and go to DONE.
  - DONE: req__bvalid = 1 and req__bresp = captured value. On req__bready, go to IDLE.
- Read FSM, one-hot states IDLE, ADDR, DATA, DONE:
  - IDLE: req__arready = 1. If req__arvalid, capture raddr and go to ADDR.
  - ADDR: arvalid = 1. On arready, go to DATA.
  - DATA: rready = 1. On rvalid, capture rdata/rresp and go to DONE.
  - DONE: req__rvalid = 1. On req__rready, go to IDLE.
- AXI rules:
  - Every valid is a function of registered state/flags only. No combinational path from any AXI ready to any AXI valid.
  - Once a valid is asserted, it and its payload stay stable until the handshake.
  - bready/rready are 0 outside RESP/DATA. Early or unexpected slave responses are therefore held off, never dropped.
- Latency, zero-wait slave:
  - Write: request accepted cycle 0; AW/W valid cycle 1; bready cycle 2; req__bvalid cycle 3 when the slave returns bvalid in cycle 2.
  - Read: same shape, with req__rvalid at cycle 3.
- Throughput: one outstanding transaction per direction. A new request is accepted in the cycle after DONE retires.
- Response codes pass through unmodified, including SLVERR/DECERR. The block never retries.
- awprot/arprot are tied to axi4l__prot. awaddr/wdata/wstrb/araddr drive from the capture registers.

Decomposition:
- Package axi4l_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - one-hot state index constants for both FSMs.
- No sub-module. The write and read FSMs are two independent process groups in one module, roughly 250 lines.

Test Plan:
- Single write, zero-wait slave: addr 0x10, data 0xDEADBEEF, strb 0xF -> AW/W valid together cycle 1, req__bvalid cycle 3, bresp 00, slave register = 0xDEADBEEF.
- AW before W: awready held low 0 cycles, wready low 4 cycles -> awvalid drops after cycle 1, wvalid stays high until cycle 5, RESP entered cycle 6, no duplicate AW handshake.
- Read with backpressure: slave arready delayed 3 cycles, returns rdata 0x12345678/rresp SLVERR; req__rready low 2 cycles -> req__rvalid held, rdata/rresp stable, req__rresp = 2'b10.
- Concurrent read and write issued same cycle -> both complete independently, no cross-channel stalls, correct data on each.
- Reset mid-write while in ADDR with awvalid high -> next cycle all valids 0, req__wready = 1, a following write completes normally.
- Slave asserts bvalid while master is still in ADDR (illegal but tolerated) -> bready stays 0 until RESP, then response is captured once.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared definitions for the AXI4-Lite master interface (axi4l_mif).
// Holds the AXI response codes and the one-hot state encodings of the
// write and read FSMs. Each state bit index is exported so that decode
// logic can test a single flop.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write FSM one-hot bit positions.
  localparam int unsigned WR_IDLE_I = 0;
  localparam int unsigned WR_ADDR_I = 1;
  localparam int unsigned WR_RESP_I = 2;
  localparam int unsigned WR_DONE_I = 3;

  // Read FSM one-hot bit positions.
  localparam int unsigned RD_IDLE_I = 0;
  localparam int unsigned RD_ADDR_I = 1;
  localparam int unsigned RD_DATA_I = 2;
  localparam int unsigned RD_DONE_I = 3;

  typedef enum logic [3:0] {
    WR_IDLE = 4'(1 << WR_IDLE_I),
    WR_ADDR = 4'(1 << WR_ADDR_I),
    WR_RESP = 4'(1 << WR_RESP_I),
    WR_DONE = 4'(1 << WR_DONE_I)
  } wr_state_e;

  typedef enum logic [3:0] {
    RD_IDLE = 4'(1 << RD_IDLE_I),
    RD_ADDR = 4'(1 << RD_ADDR_I),
    RD_DATA = 4'(1 << RD_DATA_I),
    RD_DONE = 4'(1 << RD_DONE_I)
  } rd_state_e;

endpackage

// File: rtl/axi4l_mif.sv
// AXI4-Lite master interface.
// This block converts single-beat local write and read requests into
// AXI4-Lite transactions and returns the responses to the local requester.
// The write path and the read path are independent FSMs, and they run
// concurrently. Each direction has at most one transaction outstanding.
//
// Ports:
//   sys__clk, sys__srstn       clock and synchronous active-low reset
//   req__w*/req__b*            local write request and write response
//   req__raddr/ar*/r*          local read request and read response
//   axi4l__m_aw*/w*/b*         AXI4-Lite write address, data and response channels
//   axi4l__m_ar*/r*            AXI4-Lite read address and data channels
//
// Every AXI valid and ready output is decoded from registered state and
// flags only. There is no combinational path from an AXI ready input to an
// AXI valid output. bready and rready are asserted only in RESP and DATA,
// so early responses from the slave are held off and never lost.
module axi4l_mif
  import axi4l_pkg::*;
#(
  parameter int unsigned axi4l__addr_width = 64,
  parameter int unsigned axi4l__data_width = 32,
  parameter logic [2:0]  axi4l__prot       = 3'b000
) (
  input  logic                            sys__clk,
  input  logic                            sys__srstn,
  // local write request / response
  input  logic [axi4l__addr_width-1:0]    req__waddr,
  input  logic [axi4l__data_width-1:0]    req__wdata,
  input  logic [axi4l__data_width/8-1:0]  req__wstrb,
  input  logic                            req__wvalid,
  output logic                            req__wready,
  output logic [1:0]                      req__bresp,
  output logic                            req__bvalid,
  input  logic                            req__bready,
  // local read request / response
  input  logic [axi4l__addr_width-1:0]    req__raddr,
  input  logic                            req__arvalid,
  output logic                            req__arready,
  output logic [axi4l__data_width-1:0]    req__rdata,
  output logic [1:0]                      req__rresp,
  output logic                            req__rvalid,
  input  logic                            req__rready,
  // AXI write channels
  output logic [axi4l__addr_width-1:0]    axi4l__m_awaddr,
  output logic [2:0]                      axi4l__m_awprot,
  output logic                            axi4l__m_awvalid,
  input  logic                            axi4l__m_awready,
  output logic [axi4l__data_width-1:0]    axi4l__m_wdata,
  output logic [axi4l__data_width/8-1:0]  axi4l__m_wstrb,
  output logic                            axi4l__m_wvalid,
  input  logic                            axi4l__m_wready,
  input  logic [1:0]                      axi4l__m_bresp,
  input  logic                            axi4l__m_bvalid,
  output logic                            axi4l__m_bready,
  // AXI read channels
  output logic [axi4l__addr_width-1:0]    axi4l__m_araddr,
  output logic [2:0]                      axi4l__m_arprot,
  output logic                            axi4l__m_arvalid,
  input  logic                            axi4l__m_arready,
  input  logic [axi4l__data_width-1:0]    axi4l__m_rdata,
  input  logic [1:0]                      axi4l__m_rresp,
  input  logic                            axi4l__m_rvalid,
  output logic                            axi4l__m_rready
);

  localparam int unsigned AW = axi4l__addr_width;
  localparam int unsigned DW = axi4l__data_width;
  localparam int unsigned SW = axi4l__data_width / 8;

  if (!(DW == 32 || DW == 64)) begin : g_dw_check
    $error("axi4l_mif: axi4l__data_width must be 32 or 64");
  end

  // Write path state
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_hs, w_hs;

  // Read path state
  rd_state_e         rd_state_q, rd_state_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Write path: state register
  always_ff @(posedge sys__clk) begin
    if (!sys__srstn) begin
      wr_state_q <= WR_IDLE;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  // Write path: next state and outputs
  always_comb begin
    wr_state_d       = wr_state_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    waddr_d          = waddr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    bresp_d          = bresp_q;
    req__wready      = 1'b0;
    req__bvalid      = 1'b0;
    axi4l__m_awvalid = 1'b0;
    axi4l__m_wvalid  = 1'b0;
    axi4l__m_bready  = 1'b0;
    aw_hs            = 1'b0;
    w_hs             = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        req__wready = 1'b1;
        if (req__wvalid) begin
          waddr_d    = req__waddr;
          wdata_d    = req__wdata;
          wstrb_d    = req__wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        // AW and W complete independently, in either order. Each done
        // flag drops its valid so that a channel already accepted is
        // never presented twice.
        axi4l__m_awvalid = !aw_done_q;
        axi4l__m_wvalid  = !w_done_q;
        aw_hs            = axi4l__m_awvalid && axi4l__m_awready;
        w_hs             = axi4l__m_wvalid && axi4l__m_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        axi4l__m_bready = 1'b1;
        if (axi4l__m_bvalid) begin
          bresp_d    = axi4l__m_bresp;
          wr_state_d = WR_DONE;
        end
      end
      WR_DONE: begin
        req__bvalid = 1'b1;
        if (req__bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read path: state register
  always_ff @(posedge sys__clk) begin
    if (!sys__srstn) begin
      rd_state_q <= RD_IDLE;
      raddr_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read path: next state and outputs
  always_comb begin
    rd_state_d       = rd_state_q;
    raddr_d          = raddr_q;
    rdata_d          = rdata_q;
    rresp_d          = rresp_q;
    req__arready     = 1'b0;
    req__rvalid      = 1'b0;
    axi4l__m_arvalid = 1'b0;
    axi4l__m_rready  = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        req__arready = 1'b1;
        if (req__arvalid) begin
          raddr_d    = req__raddr;
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        axi4l__m_arvalid = 1'b1;
        if (axi4l__m_arready) rd_state_d = RD_DATA;
      end
      RD_DATA: begin
        axi4l__m_rready = 1'b1;
        if (axi4l__m_rvalid) begin
          rdata_d    = axi4l__m_rdata;
          rresp_d    = axi4l__m_rresp;
          rd_state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        req__rvalid = 1'b1;
        if (req__rready) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Payloads come straight from the capture registers, so they stay stable
  // while the matching valid is held.
  assign axi4l__m_awaddr = waddr_q;
  assign axi4l__m_wdata  = wdata_q;
  assign axi4l__m_wstrb  = wstrb_q;
  assign axi4l__m_awprot = axi4l__prot;
  assign axi4l__m_araddr = raddr_q;
  assign axi4l__m_arprot = axi4l__prot;
  assign req__bresp      = bresp_q;
  assign req__rdata      = rdata_q;
  assign req__rresp      = rresp_q;

endmodule

// File: tb/tb_axi4l_mif.sv
module tb_axi4l_mif;
  import axi4l_pkg::*;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          sys__clk = 1'b0;
  logic          sys__srstn = 1'b0;
  logic [AW-1:0] req__waddr = '0;
  logic [DW-1:0] req__wdata = '0;
  logic [SW-1:0] req__wstrb = '0;
  logic          req__wvalid = 1'b0;
  logic          req__wready;
  logic [1:0]    req__bresp;
  logic          req__bvalid;
  logic          req__bready = 1'b1;
  logic [AW-1:0] req__raddr = '0;
  logic          req__arvalid = 1'b0;
  logic          req__arready;
  logic [DW-1:0] req__rdata;
  logic [1:0]    req__rresp;
  logic          req__rvalid;
  logic          req__rready = 1'b1;
  logic [AW-1:0] m_awaddr;
  logic [2:0]    m_awprot;
  logic          m_awvalid;
  logic          m_awready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wvalid;
  logic          m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid;
  logic          m_bready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arprot;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid;
  logic          m_rready;

  always #5 sys__clk = ~sys__clk;

  axi4l_mif dut (
    .sys__clk(sys__clk), .sys__srstn(sys__srstn),
    .req__waddr(req__waddr), .req__wdata(req__wdata), .req__wstrb(req__wstrb),
    .req__wvalid(req__wvalid), .req__wready(req__wready),
    .req__bresp(req__bresp), .req__bvalid(req__bvalid), .req__bready(req__bready),
    .req__raddr(req__raddr), .req__arvalid(req__arvalid), .req__arready(req__arready),
    .req__rdata(req__rdata), .req__rresp(req__rresp), .req__rvalid(req__rvalid),
    .req__rready(req__rready),
    .axi4l__m_awaddr(m_awaddr), .axi4l__m_awprot(m_awprot), .axi4l__m_awvalid(m_awvalid),
    .axi4l__m_awready(m_awready), .axi4l__m_wdata(m_wdata), .axi4l__m_wstrb(m_wstrb),
    .axi4l__m_wvalid(m_wvalid), .axi4l__m_wready(m_wready), .axi4l__m_bresp(m_bresp),
    .axi4l__m_bvalid(m_bvalid), .axi4l__m_bready(m_bready),
    .axi4l__m_araddr(m_araddr), .axi4l__m_arprot(m_arprot), .axi4l__m_arvalid(m_arvalid),
    .axi4l__m_arready(m_arready), .axi4l__m_rdata(m_rdata), .axi4l__m_rresp(m_rresp),
    .axi4l__m_rvalid(m_rvalid), .axi4l__m_rready(m_rready)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard: expectations queued at request time, popped at response.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rd_exp_t;
  logic [1:0] exp_b[$];
  rd_exp_t    exp_r[$];

  // Slave model knobs
  int            aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit            early_b = 1'b0;
  bit            use_mem = 1'b1;
  logic [1:0]    sl_bresp = RESP_OKAY;
  logic [1:0]    sl_rresp = RESP_OKAY;
  logic [DW-1:0] sl_rdata = '0;

  // Slave model state
  int            aw_cnt, w_cnt, ar_cnt;
  int            aw_hs_cnt = 0, b_hs_cnt = 0;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_data_q;
  logic [DW-1:0] mem [0:63];
  logic          sl_awhs, sl_whs;
  logic [AW-1:0] sl_wa;
  logic [DW-1:0] sl_wd;

  assign m_awready = (aw_cnt >= aw_dly);
  assign m_wready  = (w_cnt >= w_dly);
  assign m_arready = (ar_cnt >= ar_dly);
  assign sl_awhs   = m_awvalid && m_awready;
  assign sl_whs    = m_wvalid && m_wready;
  assign sl_wa     = sl_awhs ? m_awaddr : aw_addr_q;
  assign sl_wd     = sl_whs ? m_wdata : w_data_q;

  always @(posedge sys__clk) begin
    if (!sys__srstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0;
      m_bvalid <= 1'b0; m_bresp <= '0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        b_hs_cnt <= b_hs_cnt + 1;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (sl_awhs) begin
        aw_got    <= 1'b1;
        aw_addr_q <= m_awaddr;
        aw_hs_cnt <= aw_hs_cnt + 1;
        if (early_b) begin
          m_bvalid <= 1'b1;
          m_bresp  <= sl_bresp;
        end
      end
      if (sl_whs) begin
        w_got    <= 1'b1;
        w_data_q <= m_wdata;
      end
      if ((aw_got || sl_awhs) && (w_got || sl_whs)) begin
        mem[sl_wa[7:2]] <= sl_wd;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (!early_b) begin
          m_bvalid <= 1'b1;
          m_bresp  <= sl_bresp;
        end
      end
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= use_mem ? mem[m_araddr[7:2]] : sl_rdata;
        m_rresp  <= sl_rresp;
      end
    end
  end

  task automatic tick();
    @(posedge sys__clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    sys__srstn = 1'b0;
    tick();
    tick();
    obs = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
           req__bvalid, req__rvalid, req__wready, req__arready};
    checks++;
    if (obs !== 9'b0000000_11) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", obs, 9'b000000011);
    end
    checks++;
    if ({m_awaddr, m_araddr, m_wdata, m_wstrb, req__rdata, req__rresp, req__bresp} !== '0) begin
      failures++;
      $display("FAIL reset_data got awaddr=%0h araddr=%0h wdata=%0h rdata=%0h exp all zero",
               m_awaddr, m_araddr, m_wdata, req__rdata);
    end
    sys__srstn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic [1:0] e;
    req__waddr = 64'h10; req__wdata = 32'hDEADBEEF; req__wstrb = 4'hF; req__wvalid = 1'b1;
    exp_b.push_back(RESP_OKAY);
    checks++;
    if (req__wready !== 1'b1) begin
      failures++; $display("FAIL wr_accept got=%b exp=1", req__wready);
    end
    tick();
    req__wvalid = 1'b0;
    checks++;
    if ({m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, m_awprot} !==
        {2'b11, 64'h10, 32'hDEADBEEF, 4'hF, 3'b000}) begin
      failures++;
      $display("FAIL wr_cycle1 got aw=%b w=%b addr=%0h data=%0h strb=%0h prot=%0h exp 1 1 10 deadbeef f 0",
               m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, m_awprot);
    end
    tick();
    checks++;
    if ({m_bready, req__bvalid, m_awvalid, m_wvalid} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_cycle2 got bready/bvalid/aw/w=%b exp=1000",
               {m_bready, req__bvalid, m_awvalid, m_wvalid});
    end
    tick();
    checks++;
    if (req__bvalid !== 1'b1) begin
      failures++; $display("FAIL wr_cycle3_bvalid got=%b exp=1", req__bvalid);
    end else begin
      e = exp_b.pop_front();
      checks++;
      if (req__bresp !== e) begin
        failures++; $display("FAIL wr_bresp got=%b exp=%b", req__bresp, e);
      end
    end
    tick();
    checks++;
    if (req__wready !== 1'b1 || req__bvalid !== 1'b0 || mem[4] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_retire got wready=%b bvalid=%b mem=%0h exp 1 0 deadbeef",
               req__wready, req__bvalid, mem[4]);
    end
  endtask

  task automatic test_aw_before_w();
    int base;
    logic [1:0] e;
    logic [3:0] exp_v;
    aw_dly = 0; w_dly = 4;
    base = aw_hs_cnt;
    req__waddr = 64'h14; req__wdata = 32'h11112222; req__wstrb = 4'hF; req__wvalid = 1'b1;
    exp_b.push_back(RESP_OKAY);
    tick();
    req__wvalid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_v = {c == 1, c <= 5, c == 6, c == 7};
      checks++;
      if ({m_awvalid, m_wvalid, m_bready, req__bvalid} !== exp_v) begin
        failures++;
        $display("FAIL aw_first_c%0d got aw/w/bready/bvalid=%b exp=%b", c,
                 {m_awvalid, m_wvalid, m_bready, req__bvalid}, exp_v);
      end
      if (c == 7 && req__bvalid === 1'b1) begin
        e = exp_b.pop_front();
        checks++;
        if (req__bresp !== e) begin
          failures++; $display("FAIL aw_first_bresp got=%b exp=%b", req__bresp, e);
        end
      end
      tick();
    end
    checks++;
    if (aw_hs_cnt - base != 1 || mem[5] !== 32'h11112222) begin
      failures++;
      $display("FAIL aw_first_once got aw_hs=%0d mem=%0h exp 1 11112222", aw_hs_cnt - base, mem[5]);
    end
    w_dly = 0;
  endtask

  task automatic test_read_backpressure();
    int cyc;
    rd_exp_t e;
    ar_dly = 3; use_mem = 1'b0; sl_rdata = 32'h12345678; sl_rresp = RESP_SLVERR;
    req__raddr = 64'h40; req__arvalid = 1'b1; req__rready = 1'b0;
    exp_r.push_back('{d: 32'h12345678, r: RESP_SLVERR});
    checks++;
    if (req__arready !== 1'b1) begin
      failures++; $display("FAIL rd_accept got=%b exp=1", req__arready);
    end
    tick();
    req__arvalid = 1'b0;
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== 64'h40 || m_arprot !== 3'b000) begin
      failures++;
      $display("FAIL rd_cycle1 got arvalid=%b araddr=%0h exp 1 40", m_arvalid, m_araddr);
    end
    cyc = 1;
    while (req__rvalid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 6) begin
      failures++; $display("FAIL rd_latency got cycle=%0d exp=6", cyc);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (req__rvalid !== 1'b1 || req__rdata !== exp_r[0].d || req__rresp !== exp_r[0].r) begin
        failures++;
        $display("FAIL rd_hold%0d got rvalid=%b rdata=%0h rresp=%b exp 1 %0h %b", k,
                 req__rvalid, req__rdata, req__rresp, exp_r[0].d, exp_r[0].r);
      end
      tick();
    end
    req__rready = 1'b1;
    e = exp_r.pop_front();
    checks++;
    if (req__rvalid !== 1'b1 || req__rdata !== e.d || req__rresp !== e.r) begin
      failures++;
      $display("FAIL rd_resp got rvalid=%b rdata=%0h rresp=%b exp 1 %0h %b",
               req__rvalid, req__rdata, req__rresp, e.d, e.r);
    end
    tick();
    checks++;
    if (req__rvalid !== 1'b0 || req__arready !== 1'b1) begin
      failures++;
      $display("FAIL rd_retire got rvalid=%b arready=%b exp 0 1", req__rvalid, req__arready);
    end
    ar_dly = 0; use_mem = 1'b1; sl_rresp = RESP_OKAY;
  endtask

  task automatic test_concurrent();
    logic [1:0] eb;
    rd_exp_t er;
    int cyc;
    req__waddr = 64'h20; req__wdata = 32'hA5A50001; req__wstrb = 4'hF; req__wvalid = 1'b1;
    req__raddr = 64'h10; req__arvalid = 1'b1;
    exp_b.push_back(RESP_OKAY);
    exp_r.push_back('{d: 32'hDEADBEEF, r: RESP_OKAY});
    tick();
    req__wvalid = 1'b0; req__arvalid = 1'b0;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b111) begin
      failures++;
      $display("FAIL conc_cycle1 got aw/w/ar=%b exp=111", {m_awvalid, m_wvalid, m_arvalid});
    end
    tick();
    tick();
    checks++;
    if ({req__bvalid, req__rvalid} !== 2'b11) begin
      failures++;
      $display("FAIL conc_cycle3 got bvalid/rvalid=%b exp=11", {req__bvalid, req__rvalid});
    end else begin
      eb = exp_b.pop_front();
      er = exp_r.pop_front();
      checks++;
      if (req__bresp !== eb || req__rdata !== er.d || req__rresp !== er.r) begin
        failures++;
        $display("FAIL conc_resp got bresp=%b rdata=%0h rresp=%b exp %b %0h %b",
                 req__bresp, req__rdata, req__rresp, eb, er.d, er.r);
      end
    end
    tick();
    req__raddr = 64'h20; req__arvalid = 1'b1;
    exp_r.push_back('{d: 32'hA5A50001, r: RESP_OKAY});
    tick();
    req__arvalid = 1'b0;
    cyc = 1;
    while (req__rvalid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    er = exp_r.pop_front();
    checks++;
    if (req__rvalid !== 1'b1 || req__rdata !== er.d) begin
      failures++;
      $display("FAIL conc_readback got rvalid=%b rdata=%0h exp 1 %0h", req__rvalid, req__rdata, er.d);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    logic [1:0] e;
    aw_dly = 20; w_dly = 20;
    req__waddr = 64'h30; req__wdata = 32'h55555555; req__wstrb = 4'hF; req__wvalid = 1'b1;
    tick();
    req__wvalid = 1'b0;
    tick();
    checks++;
    if (m_awvalid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre got awvalid=%b exp=1", m_awvalid);
    end
    sys__srstn = 1'b0;
    tick();
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req__wready, req__arready} !== 7'b0000011
        || m_awaddr !== '0) begin
      failures++;
      $display("FAIL rst_mid_post got valids=%b awaddr=%0h exp 0000011 0",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req__wready, req__arready}, m_awaddr);
    end
    sys__srstn = 1'b1;
    aw_dly = 0; w_dly = 0;
    tick();
    req__waddr = 64'h30; req__wdata = 32'h0BADF00D; req__wvalid = 1'b1;
    exp_b.push_back(RESP_OKAY);
    tick();
    req__wvalid = 1'b0;
    cyc = 1;
    while (req__bvalid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 3) begin
      failures++; $display("FAIL rst_mid_after_latency got cycle=%0d exp=3", cyc);
    end
    e = exp_b.pop_front();
    checks++;
    if (req__bresp !== e) begin
      failures++; $display("FAIL rst_mid_after_bresp got=%b exp=%b", req__bresp, e);
    end
    tick();
    checks++;
    if (mem[12] !== 32'h0BADF00D) begin
      failures++; $display("FAIL rst_mid_after_mem got=%0h exp=0badf00d", mem[12]);
    end
  endtask

  task automatic test_early_bvalid();
    int base;
    logic [1:0] e;
    logic [1:0] exp_v;
    early_b = 1'b1; w_dly = 3; sl_bresp = RESP_DECERR;
    base = b_hs_cnt;
    req__waddr = 64'h34; req__wdata = 32'hCAFE0001; req__wstrb = 4'hF; req__wvalid = 1'b1;
    exp_b.push_back(RESP_DECERR);
    tick();
    req__wvalid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2 && c <= 4) begin
        exp_v = 2'b10;
        checks++;
        if ({m_bvalid, m_bready} !== exp_v) begin
          failures++;
          $display("FAIL early_b_c%0d got bvalid/bready=%b exp=%b", c, {m_bvalid, m_bready}, exp_v);
        end
      end
      if (c == 5) begin
        checks++;
        if (m_bready !== 1'b1 || req__bvalid !== 1'b0) begin
          failures++;
          $display("FAIL early_b_resp got bready=%b req_bvalid=%b exp 1 0", m_bready, req__bvalid);
        end
      end
      if (c == 6) begin
        e = exp_b.pop_front();
        checks++;
        if (req__bvalid !== 1'b1 || req__bresp !== e) begin
          failures++;
          $display("FAIL early_b_done got bvalid=%b bresp=%b exp 1 %b", req__bvalid, req__bresp, e);
        end
      end
      tick();
    end
    checks++;
    if (b_hs_cnt - base != 1 || m_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL early_b_once got b_hs=%0d bvalid=%b exp 1 0", b_hs_cnt - base, m_bvalid);
    end
    early_b = 1'b0; w_dly = 0; sl_bresp = RESP_OKAY;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_aw_before_w();
    test_read_backpressure();
    test_concurrent();
    test_reset_mid_write();
    test_early_bvalid();
    checks++;
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got b=%0d r=%0d exp 0 0", exp_b.size(), exp_r.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
